// File: rtl/z80_irq_timer_if.sv
// CPU-side bus of the interrupt timer: strobes, register select, data and interrupt lines.
// The master modport drives the peripheral; the slave modport is the timer itself.
interface z80_irq_timer_if;
    logic       n_wr;
    logic       n_rd;
    logic [1:0] regAddr;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic [1:0] n_irqIn;
    logic       n_int;
    logic       tick;

    modport master (
        output n_wr, n_rd, regAddr, dataIn, n_irqIn,
        input  dataOut, n_int, tick
    );

    modport slave (
        input  n_wr, n_rd, regAddr, dataIn, n_irqIn,
        output dataOut, n_int, tick
    );
endinterface

// File: rtl/z80_irq_timer.sv
// Periodic tick timer plus UART/display interrupt combiner feeding the Z80 int_n input.
// I/O registers: 0 CTRL, 1 STATUS, 2 RELOAD_LO, 3 RELOAD_HI.
module z80_irq_timer #(
    parameter int unsigned PRESCALE     = 25000,
    parameter logic [15:0] RESET_RELOAD = 16'd999
) (
    input  logic                  clk,
    input  logic                  reset,
    z80_irq_timer_if.slave        io_bus
);
    localparam logic [15:0] PresLast = 16'(PRESCALE - 1);

    logic        r_nwr;
    logic        r_nrd;
    logic [3:0]  r_ctrl;
    logic [15:0] r_reload;
    logic [15:0] r_count;
    logic [15:0] r_presc;
    logic        r_tf;
    logic [1:0]  r_req_s1;
    logic [1:0]  r_req_s2;
    logic        r_nint;
    logic        r_tick;

    logic [3:0]  w_ctrl_nxt;
    logic [15:0] w_reload_nxt;
    logic [15:0] w_count_nxt;
    logic [15:0] w_presc_nxt;
    logic        w_tf_nxt;
    logic        w_wr;
    logic        w_rd_rise;
    logic        w_reload_now;
    logic        w_tick_en;
    logic        w_expire;
    logic        w_irq;
    logic [7:0]  w_rdata;

    // Strobes are edge-detected against their registered copies so a long strobe acts once.
    assign w_wr         = r_nwr & ~io_bus.n_wr;
    assign w_rd_rise    = ~r_nrd & io_bus.n_rd & (io_bus.regAddr == 2'd1);
    assign w_reload_now = w_wr & (io_bus.regAddr == 2'd0) & io_bus.dataIn[7];
    assign w_tick_en    = r_ctrl[0] & (r_presc == PresLast);
    assign w_expire     = w_tick_en & (r_count == 16'd0);
    assign w_irq        = (r_tf & r_ctrl[1]) | (r_req_s2[0] & r_ctrl[2]) | (r_req_s2[1] & r_ctrl[3]);

    always_comb begin
        w_ctrl_nxt   = r_ctrl;
        w_reload_nxt = r_reload;
        if (w_wr) begin
            case (io_bus.regAddr)
                2'd0:    w_ctrl_nxt          = io_bus.dataIn[3:0];
                2'd2:    w_reload_nxt[7:0]   = io_bus.dataIn;
                2'd3:    w_reload_nxt[15:8]  = io_bus.dataIn;
                default: ;
            endcase
        end

        w_count_nxt = r_count;
        if (w_reload_now || w_expire) begin
            w_count_nxt = w_reload_nxt;
        end else if (w_tick_en) begin
            w_count_nxt = r_count - 16'd1;
        end

        // Prescaler restarts from 0 on start, stop, forced reload and every completed tick.
        w_presc_nxt = 16'd0;
        if (r_ctrl[0] && w_ctrl_nxt[0] && !w_reload_now && !w_tick_en) begin
            w_presc_nxt = r_presc + 16'd1;
        end

        // An expiry on the same clk as the clearing read leaves the flag set.
        w_tf_nxt = r_tf;
        if (w_expire) begin
            w_tf_nxt = 1'b1;
        end else if (w_rd_rise) begin
            w_tf_nxt = 1'b0;
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        unique case (io_bus.regAddr)
            2'd0: w_rdata = {4'b0000, r_ctrl};
            2'd1: w_rdata = {5'b00000, r_req_s2[1], r_req_s2[0], r_tf};
            2'd2: w_rdata = r_reload[7:0];
            2'd3: w_rdata = r_reload[15:8];
        endcase
    end

    // r_nwr resets low so a strobe already in progress at reset release is not taken as a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nwr    <= 1'b0;
            r_nrd    <= 1'b1;
            r_ctrl   <= 4'h0;
            r_reload <= RESET_RELOAD;
            r_count  <= RESET_RELOAD;
            r_presc  <= 16'd0;
            r_tf     <= 1'b0;
            r_req_s1 <= 2'b00;
            r_req_s2 <= 2'b00;
            r_nint   <= 1'b1;
            r_tick   <= 1'b0;
        end else begin
            r_nwr    <= io_bus.n_wr;
            r_nrd    <= io_bus.n_rd;
            r_ctrl   <= w_ctrl_nxt;
            r_reload <= w_reload_nxt;
            r_count  <= w_count_nxt;
            r_presc  <= w_presc_nxt;
            r_tf     <= w_tf_nxt;
            r_req_s1 <= ~io_bus.n_irqIn;
            r_req_s2 <= r_req_s1;
            r_nint   <= ~w_irq;
            r_tick   <= w_expire;
        end
    end

    assign io_bus.dataOut = w_rdata;
    assign io_bus.n_int   = r_nint;
    assign io_bus.tick    = r_tick;
endmodule

// File: tb/tb_z80_irq_timer.sv
// Bench for z80_irq_timer: directed scenarios plus random bus traffic against a reference model,
// with a scoreboard monitor checking n_int/tick every clk and read data on every read strobe.
module tb_z80_irq_timer;
    localparam int unsigned Prescale = 4;

    logic clk;
    logic reset;
    z80_irq_timer_if bus ();

    z80_irq_timer #(.PRESCALE(Prescale)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    typedef struct {
        int unsigned cyc;
        bit          nint;
        bit          tick;
    } exp_t;

    exp_t       q_out[$];
    logic [7:0] q_rd[$];

    // Reference model: architectural state as described by the register map and timer rules.
    logic [3:0]  m_ctrl;
    logic [15:0] m_reload;
    logic [15:0] m_count;
    int unsigned m_presc;
    bit          m_tf;
    bit [1:0]    m_req1;
    bit [1:0]    m_req2;
    bit          m_nwr_seen;
    bit          m_nrd_seen;

    function automatic void model_reset();
        m_ctrl     = 4'h0;
        m_reload   = 16'd999;
        m_count    = 16'd999;
        m_presc    = 0;
        m_tf       = 1'b0;
        m_req1     = 2'b00;
        m_req2     = 2'b00;
        m_nwr_seen = 1'b0;
        m_nrd_seen = 1'b1;
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {4'h0, m_ctrl};
            2'd1:    return {5'b0, m_req2[1], m_req2[0], m_tf};
            2'd2:    return m_reload[7:0];
            default: return m_reload[15:8];
        endcase
    endfunction

    function automatic bit model_will_expire();
        return m_ctrl[0] && (m_presc == Prescale - 1) && (m_count == 16'd0);
    endfunction

    // Advance the model across the coming clock edge using the inputs now on the bus.
    function automatic void model_step();
        bit   ten_before, wr_evt, rd_clr, tick_en, expire, irq, reload_now;
        exp_t e;
        ten_before = m_ctrl[0];
        irq        = (m_tf && m_ctrl[1]) || (m_req2[0] && m_ctrl[2]) || (m_req2[1] && m_ctrl[3]);
        wr_evt     = m_nwr_seen && !bus.n_wr;
        rd_clr     = !m_nrd_seen && bus.n_rd && (bus.regAddr == 2'd1);
        tick_en    = ten_before && (m_presc == Prescale - 1);
        expire     = tick_en && (m_count == 16'd0);
        reload_now = 1'b0;
        if (wr_evt) begin
            case (bus.regAddr)
                2'd0: begin
                    m_ctrl     = bus.dataIn[3:0];
                    reload_now = bus.dataIn[7];
                end
                2'd2:    m_reload = {m_reload[15:8], bus.dataIn};
                2'd3:    m_reload = {bus.dataIn, m_reload[7:0]};
                default: ;
            endcase
        end
        if (reload_now || expire) m_count = m_reload;
        else if (tick_en)         m_count = m_count - 16'd1;
        if (!ten_before || !m_ctrl[0] || reload_now || tick_en) m_presc = 0;
        else                                                    m_presc = m_presc + 1;
        if (expire)      m_tf = 1'b1;
        else if (rd_clr) m_tf = 1'b0;
        m_req2     = m_req1;
        m_req1     = ~bus.n_irqIn;
        m_nwr_seen = bus.n_wr;
        m_nrd_seen = bus.n_rd;
        e.cyc  = cyc + 1;
        e.nint = !irq;
        e.tick = expire;
        q_out.push_back(e);
    endfunction

    // Monitor: compares registered outputs each clk and read data at each read strobe start.
    exp_t mon_e;
    logic [7:0] mon_rd;
    bit mon_rd_prev = 1'b1;
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (q_out.size() > 0 && q_out[0].cyc == cyc) begin
                mon_e = q_out.pop_front();
                check("n_int", 32'(bus.n_int), 32'(mon_e.nint));
                check("tick", 32'(bus.tick), 32'(mon_e.tick));
            end
            if (!bus.n_rd && mon_rd_prev) begin
                if (q_rd.size() == 0) begin
                    check("unexpected_read", 32'(1), 32'(0));
                end else begin
                    mon_rd = q_rd.pop_front();
                    check("read_data", 32'(bus.dataOut), 32'(mon_rd));
                end
            end
        end
        mon_rd_prev = bus.n_rd;
    end

    task automatic clk_step();
        model_step();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int len);
        bus.regAddr = a;
        bus.dataIn  = d;
        bus.n_wr    = 1'b0;
        repeat (len) clk_step();
        bus.n_wr = 1'b1;
        clk_step();
    endtask

    task automatic bus_read(input logic [1:0] a, input int len);
        bus.regAddr = a;
        bus.n_rd    = 1'b0;
        q_rd.push_back(model_read(a));
        repeat (len) clk_step();
        bus.n_rd = 1'b1;
        clk_step();
    endtask

    task automatic wait_tick(input int budget, output int unsigned t);
        t = 0;
        for (int i = 0; i < budget; i++) begin
            clk_step();
            if (bus.tick) begin
                t = cyc;
                return;
            end
        end
        check("wait_tick_timeout", 32'(1), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0]  rst_vals [4];
    int unsigned t1, t2;
    int          nticks;
    bit          done;

    initial begin
        rst_vals    = '{8'h00, 8'h00, 8'hE7, 8'h03};
        reset       = 1'b1;
        bus.n_wr    = 1'b1;
        bus.n_rd    = 1'b1;
        bus.regAddr = 2'd0;
        bus.dataIn  = 8'h00;
        bus.n_irqIn = 2'b11;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_n_int", 32'(bus.n_int), 32'(1));
        check("reset_tick", 32'(bus.tick), 32'(0));
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.regAddr = 2'(i);
            #1;
            check("reset_reg", 32'(bus.dataOut), 32'(rst_vals[i]));
        end
        bus.regAddr = 2'd0;
        repeat (2) clk_step();

        // Periodic ticks with RELOAD=2: one expiry every 12 clks, read of STATUS clears TF.
        bus_write(2'd2, 8'h02, 1);
        bus_write(2'd3, 8'h00, 1);
        bus_write(2'd0, 8'h83, 1);
        wait_tick(40, t1);
        clk_step();
        check("tf_irq_after_tick", 32'(bus.n_int), 32'(0));
        bus_read(2'd1, 2);
        clk_step();
        check("n_int_after_status_read", 32'(bus.n_int), 32'(1));
        wait_tick(40, t2);
        check("tick_period", t2 - t1, 32'd12);

        // Long strobes: one update each; stopped timer stays frozen.
        bus_write(2'd0, 8'h00, 5);
        bus_write(2'd0, 8'h01, 5);
        repeat (30) clk_step();
        bus_write(2'd0, 8'h00, 5);
        nticks = 0;
        for (int i = 0; i < 100; i++) begin
            clk_step();
            if (bus.tick) nticks++;
        end
        check("frozen_no_ticks", 32'(nticks), 32'(0));

        // STATUS read rising edge coinciding with an expiry: set wins.
        bus_write(2'd0, 8'h83, 1);
        wait_tick(40, t1);
        bus.regAddr = 2'd1;
        bus.n_rd    = 1'b0;
        q_rd.push_back(model_read(2'd1));
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (model_will_expire()) begin
                bus.n_rd = 1'b1;
                done     = 1'b1;
            end
            clk_step();
        end
        bus.n_rd = 1'b1;
        check("coincide_reached", 32'(done), 32'(1));
        repeat (2) clk_step();
        check("coincide_n_int", 32'(bus.n_int), 32'(0));
        #1;
        check("coincide_tf", 32'(bus.dataOut[0]), 32'(1));

        // External request gating and synchroniser latency.
        bus_write(2'd0, 8'h04, 1);
        bus_read(2'd1, 1);
        bus.regAddr = 2'd1;
        bus.n_irqIn = 2'b10;
        repeat (2) clk_step();
        check("uart_n_int_not_yet", 32'(bus.n_int), 32'(1));
        clk_step();
        check("uart_n_int_low", 32'(bus.n_int), 32'(0));
        #1;
        check("uart_status", 32'(bus.dataOut), 32'(8'h02));
        bus.n_irqIn = 2'b11;
        repeat (3) clk_step();
        check("uart_n_int_release", 32'(bus.n_int), 32'(1));
        bus_write(2'd0, 8'h00, 1);
        bus.regAddr = 2'd1;
        bus.n_irqIn = 2'b10;
        repeat (5) clk_step();
        check("uart_masked_n_int", 32'(bus.n_int), 32'(1));
        #1;
        check("uart_masked_status", 32'(bus.dataOut), 32'(8'h02));
        bus.n_irqIn = 2'b11;
        clk_step();

        // Random traffic against the model.
        bus_write(2'd2, 8'h03, 1);
        bus_write(2'd3, 8'h00, 1);
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 2) begin
                logic [1:0] a;
                logic [7:0] d;
                a = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                if (a == 2'd2) d = 8'($urandom_range(0, 7));
                if (a == 2'd3) d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
                if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
                bus_write(a, d, int'($urandom_range(1, 4)));
            end else if (op <= 4) begin
                bus_read(2'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            end else if (op == 5) begin
                bus.n_irqIn = 2'($urandom);
                clk_step();
            end else begin
                repeat ($urandom_range(1, 10)) clk_step();
            end
        end
        bus.n_irqIn = 2'b11;

        // Asynchronous reset during a write strobe; no write until n_wr is seen high again.
        bus_write(2'd2, 8'h01, 1);
        bus_write(2'd3, 8'h00, 1);
        bus_write(2'd0, 8'h83, 1);
        repeat (5) clk_step();
        bus.regAddr = 2'd2;
        bus.dataIn  = 8'hAA;
        bus.n_wr    = 1'b0;
        repeat (2) clk_step();
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_n_int", 32'(bus.n_int), 32'(1));
        check("async_reset_tick", 32'(bus.tick), 32'(0));
        check("async_reset_reload_lo", 32'(bus.dataOut), 32'(8'hE7));
        bus.regAddr = 2'd0;
        #1;
        check("async_reset_ctrl", 32'(bus.dataOut), 32'(8'h00));
        model_reset();
        bus.regAddr = 2'd2;
        bus.dataIn  = 8'h55;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) clk_step();
        #1;
        check("no_write_after_reset", 32'(bus.dataOut), 32'(8'hE7));
        bus.n_wr = 1'b1;
        clk_step();
        bus_write(2'd2, 8'h55, 1);
        #1;
        check("write_after_reset", 32'(bus.dataOut), 32'(8'h55));
        bus_read(2'd2, 1);

        repeat (3) clk_step();
        #3;
        check("rd_queue_drained", 32'(q_rd.size()), 32'(0));
        check("out_queue_drained", 32'(q_out.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
